reg_bank_timer: RTL and testbench

Register-file slave that sits directly downstream of the AXI register bridge and consumes its register-file interface (read/write strobes, register indices, write data) and returns read data. It implements eight 32-bit registers: ID, scratch, a countdown timer with optional auto-reload, a W1C status register, and a saturating event counter. It drives a level interrupt to the PS.

---
 rtl/reg_bank_pkg.sv | 27 ++
 rtl/reg_timer.sv | 63 ++++++
 rtl/reg_bank_timer.sv | 105 ++++++++++
 tb/tb_reg_bank_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared register map, field positions and timer state encoding for reg_bank_timer.
package reg_bank_pkg;

    localparam int unsigned R_ADDR_WIDTH = 3;
    localparam logic [31:0] ID_VALUE     = 32'h5242_5401;

    localparam logic [R_ADDR_WIDTH-1:0] REG_ID      = 3'd0;
    localparam logic [R_ADDR_WIDTH-1:0] REG_SCRATCH = 3'd1;
    localparam logic [R_ADDR_WIDTH-1:0] REG_CTRL    = 3'd2;
    localparam logic [R_ADDR_WIDTH-1:0] REG_RELOAD  = 3'd3;
    localparam logic [R_ADDR_WIDTH-1:0] REG_COUNT   = 3'd4;
    localparam logic [R_ADDR_WIDTH-1:0] REG_STATUS  = 3'd5;
    localparam logic [R_ADDR_WIDTH-1:0] REG_EVTCNT  = 3'd6;
    localparam logic [R_ADDR_WIDTH-1:0] REG_RSVD    = 3'd7;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_AR    = 1;
    localparam int unsigned CTRL_IE    = 2;
    localparam int unsigned STATUS_EXP = 0;
    localparam int unsigned STATUS_RUN = 1;

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tstate_t;

endpackage

// File: rtl/reg_timer.sv
// Countdown timer FSM: loads from RELOAD, expires when COUNT reaches 1 (or 0), optional reload.
module reg_timer
    import reg_bank_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        stop_i,
    input  logic        ar_i,
    input  logic [31:0] reload_i,
    output logic [31:0] count_o,
    output logic        run_o,
    output logic        expire_o
);

    tstate_t     state_q, state_d;
    logic [31:0] count_q, count_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        expire_o = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (load_i) begin
                    state_d = T_RUN;
                    count_d = reload_i;
                end
            end
            T_RUN: begin
                // A stop request wins over an expiry on the same edge; COUNT is frozen.
                if (stop_i) begin
                    state_d = T_IDLE;
                end else if (count_q <= 32'd1) begin
                    expire_o = 1'b1;
                    if (ar_i) begin
                        count_d = reload_i;
                    end else begin
                        count_d = '0;
                        state_d = T_IDLE;
                    end
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign run_o   = (state_q == T_RUN);

endmodule

// File: rtl/reg_bank_timer.sv
// Eight-register slave: ID, scratch, countdown timer, W1C status, saturating event counter.
module reg_bank_timer
    import reg_bank_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [R_ADDR_WIDTH-1:0] i_rreg,
    input  logic                    i_rd,
    output logic [31:0]             o_rdata,
    input  logic [R_ADDR_WIDTH-1:0] i_wreg,
    input  logic [31:0]             i_wdata,
    input  logic                    i_wr,
    input  logic                    i_evt,
    output logic                    o_irq
);

    logic [31:0] scratch_q, scratch_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] evtcnt_q, evtcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        exp_q, exp_d;

    logic [31:0] count;
    logic        run;
    logic        expire;
    logic        wr_ctrl;

    assign wr_ctrl = i_wr && (i_wreg == REG_CTRL);

    reg_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (wr_ctrl && i_wdata[CTRL_EN]),
        .stop_i   (wr_ctrl && !i_wdata[CTRL_EN]),
        .ar_i     (ctrl_q[CTRL_AR]),
        .reload_i (reload_q),
        .count_o  (count),
        .run_o    (run),
        .expire_o (expire)
    );

    always_comb begin
        scratch_d = scratch_q;
        reload_d  = reload_q;
        ctrl_d    = ctrl_q;
        exp_d     = exp_q;
        evtcnt_d  = evtcnt_q;

        if (i_wr && (i_wreg == REG_SCRATCH)) scratch_d = i_wdata;
        if (i_wr && (i_wreg == REG_RELOAD))  reload_d  = i_wdata;
        if (wr_ctrl)                         ctrl_d    = i_wdata[2:0];
        if (i_wr && (i_wreg == REG_STATUS) && i_wdata[STATUS_EXP]) exp_d = 1'b0;

        // A one-shot expiry drops EN after any same-edge CTRL write; a new EXP beats W1C.
        if (expire) begin
            exp_d = 1'b1;
            if (!ctrl_q[CTRL_AR]) ctrl_d[CTRL_EN] = 1'b0;
        end

        if (i_wr && (i_wreg == REG_EVTCNT)) begin
            evtcnt_d = {31'd0, i_evt};
        end else if (i_evt && (evtcnt_q != 32'hFFFF_FFFF)) begin
            evtcnt_d = evtcnt_q + 32'd1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (i_rd) begin
            case (i_rreg)
                REG_ID:      rdata_d = ID_VALUE;
                REG_SCRATCH: rdata_d = scratch_q;
                REG_CTRL:    rdata_d = {29'd0, ctrl_q};
                REG_RELOAD:  rdata_d = reload_q;
                REG_COUNT:   rdata_d = count;
                REG_STATUS:  rdata_d = {30'd0, run, exp_q};
                REG_EVTCNT:  rdata_d = evtcnt_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch_q <= '0;
            reload_q  <= '0;
            evtcnt_q  <= '0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            exp_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            reload_q  <= reload_d;
            evtcnt_q  <= evtcnt_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            exp_q     <= exp_d;
        end
    end

    assign o_rdata = rdata_q;
    assign o_irq   = exp_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_reg_bank_timer.sv
// Self-checking bench for reg_bank_timer: directed vector table, corner sequences, random vs model.
module tb_reg_bank_timer;

    localparam logic [31:0] ID = 32'h5242_5401;

    logic        clk;
    logic        rst_n;
    logic [2:0]  i_rreg;
    logic        i_rd;
    logic [31:0] o_rdata;
    logic [2:0]  i_wreg;
    logic [31:0] i_wdata;
    logic        i_wr;
    logic        i_evt;
    logic        o_irq;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_timer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rreg  (i_rreg),
        .i_rd    (i_rd),
        .o_rdata (o_rdata),
        .i_wreg  (i_wreg),
        .i_wdata (i_wdata),
        .i_wr    (i_wr),
        .i_evt   (i_evt),
        .o_irq   (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rd;
        bit [2:0]  rr;
        bit        wr;
        bit [2:0]  wi;
        bit [31:0] wd;
        bit        evt;
        bit        chk;
        bit [31:0] er;
        bit        ei;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: register contents plus "timer running" and "cycles left" counters.
    bit [31:0] m_scratch, m_reload, m_count, m_evt, m_rdata;
    bit [2:0]  m_ctrl;
    bit        m_run, m_exp;

    function automatic void model_reset();
        m_scratch = 0; m_reload = 0; m_count = 0; m_evt = 0; m_rdata = 0;
        m_ctrl = 0; m_run = 0; m_exp = 0;
    endfunction

    function automatic bit [31:0] model_read(bit [2:0] r);
        case (r)
            3'd0:    return ID;
            3'd1:    return m_scratch;
            3'd2:    return {29'd0, m_ctrl};
            3'd3:    return m_reload;
            3'd4:    return m_count;
            3'd5:    return {30'd0, m_run, m_exp};
            3'd6:    return m_evt;
            default: return 0;
        endcase
    endfunction

    function automatic void model_edge(bit rd, bit [2:0] rr, bit wr, bit [2:0] wi,
                                       bit [31:0] wd, bit evt);
        bit fired   = 0;
        bit auto_rl = m_ctrl[1];
        bit [31:0] old_reload = m_reload;
        if (rd) m_rdata = model_read(rr);
        if (m_run) begin
            if (wr && wi == 3'd2 && !wd[0]) begin
                m_run = 0;
            end else if (m_count <= 1) begin
                fired = 1;
                if (auto_rl) m_count = old_reload;
                else begin m_count = 0; m_run = 0; end
            end else begin
                m_count = m_count - 1;
            end
        end else if (wr && wi == 3'd2 && wd[0]) begin
            m_run   = 1;
            m_count = old_reload;
        end
        if (wr && wi == 3'd1) m_scratch = wd;
        if (wr && wi == 3'd2) m_ctrl = wd[2:0];
        if (wr && wi == 3'd3) m_reload = wd;
        if (wr && wi == 3'd5 && wd[0]) m_exp = 0;
        if (fired) begin
            m_exp = 1;
            if (!auto_rl) m_ctrl[0] = 0;
        end
        if (wr && wi == 3'd6) m_evt = evt ? 1 : 0;
        else if (evt && m_evt != 32'hFFFF_FFFF) m_evt = m_evt + 1;
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void add(bit rd, bit [2:0] rr, bit wr, bit [2:0] wi, bit [31:0] wd,
                                bit evt, bit chk, bit [31:0] er, bit ei);
        vecs.push_back('{rd, rr, wr, wi, wd, evt, chk, er, ei});
    endfunction

    function automatic void idle(int n, bit ei);
        for (int k = 0; k < n; k++) add(0, 0, 0, 0, 0, 0, 0, 0, ei);
    endfunction

    task automatic tick(bit rd, bit [2:0] rr, bit wr, bit [2:0] wi, bit [31:0] wd, bit evt);
        @(negedge clk);
        i_rd = rd; i_rreg = rr; i_wr = wr; i_wreg = wi; i_wdata = wd; i_evt = evt;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(rd, rr, wr, wi, wd, evt);
        #1;
    endtask

    initial begin
        i_rd = 0; i_rreg = 0; i_wr = 0; i_wreg = 0; i_wdata = 0; i_evt = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Start a long auto-reload run, then abort it with reset.
        tick(0, 0, 1, 3'd3, 32'd100, 0);
        tick(0, 0, 1, 3'd2, 32'd7, 0);
        tick(1, 3'd4, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset rdata", o_rdata, 32'd0);
        check("async reset irq", {31'd0, o_irq}, 32'd0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) add(1, 3'(r), 0, 0, 0, 0, 1, (r == 0) ? ID : 32'd0, 0);
        // Scratch and read-during-write
        add(0, 0, 1, 3'd1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        add(1, 3'd1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        add(1, 3'd1, 1, 3'd1, 32'h1, 0, 1, 32'hDEAD_BEEF, 0);
        add(1, 3'd1, 0, 0, 0, 0, 1, 32'h1, 0);
        // One-shot, RELOAD=5, IE set
        add(0, 0, 1, 3'd3, 32'd5, 0, 0, 0, 0);
        add(0, 0, 1, 3'd2, 32'h5, 0, 0, 0, 0);
        add(1, 3'd4, 0, 0, 0, 0, 1, 32'd5, 0);
        idle(2, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h2, 0);
        idle(1, 1);
        add(1, 3'd2, 0, 0, 0, 0, 1, 32'h4, 1);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h1, 1);
        add(1, 3'd4, 0, 0, 0, 0, 1, 32'h0, 1);
        add(0, 0, 1, 3'd5, 32'h1, 0, 0, 0, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h0, 0);
        // Auto-reload, RELOAD=3, then RELOAD=7 mid-run
        add(0, 0, 1, 3'd3, 32'd3, 0, 0, 0, 0);
        add(0, 0, 1, 3'd2, 32'h3, 0, 0, 0, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h2, 0);
        add(1, 3'd4, 0, 0, 0, 0, 1, 32'd2, 0);
        idle(1, 0);
        add(1, 3'd5, 1, 3'd5, 32'h1, 0, 1, 32'h3, 0);
        add(1, 3'd5, 1, 3'd3, 32'd7, 0, 1, 32'h2, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h2, 0);
        add(1, 3'd5, 1, 3'd5, 32'h1, 0, 1, 32'h3, 0);
        idle(4, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h2, 0);
        idle(1, 0);
        add(1, 3'd5, 1, 3'd5, 32'h1, 0, 1, 32'h3, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h2, 0);
        idle(4, 0);
        // W1C on the expiry edge: the set wins
        add(0, 0, 1, 3'd5, 32'h1, 0, 0, 0, 0);
        add(1, 3'd5, 1, 3'd5, 32'h1, 0, 1, 32'h3, 0);
        idle(5, 0);
        // CTRL=0 on the expiry edge: stop wins, COUNT held at 1
        add(0, 0, 1, 3'd2, 32'h0, 0, 0, 0, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h0, 0);
        add(1, 3'd4, 0, 0, 0, 0, 1, 32'h1, 0);
        add(1, 3'd2, 0, 0, 0, 0, 1, 32'h0, 0);
        // Event counter
        for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 3'd6, 0, 0, 0, 0, 1, 32'd10, 0);
        add(0, 0, 1, 3'd6, 32'h1234, 1, 0, 0, 0);
        add(1, 3'd6, 0, 0, 0, 0, 1, 32'd1, 0);
        // Reserved index
        add(0, 0, 1, 3'd7, 32'hFFFF_FFFF, 0, 0, 0, 0);
        add(1, 3'd7, 0, 0, 0, 0, 1, 32'd0, 0);
        // RELOAD=0 behaves as a one-cycle period
        add(0, 0, 1, 3'd3, 32'd0, 0, 0, 0, 0);
        add(0, 0, 1, 3'd2, 32'h1, 0, 0, 0, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h2, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h1, 0);
        add(1, 3'd4, 1, 3'd5, 32'h1, 0, 1, 32'h0, 0);
        add(1, 3'd5, 0, 0, 0, 0, 1, 32'h0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].rd, vecs[i].rr, vecs[i].wr, vecs[i].wi, vecs[i].wd, vecs[i].evt);
            if (vecs[i].chk) check($sformatf("vec%0d rdata", i), o_rdata, vecs[i].er);
            check($sformatf("vec%0d irq", i), {31'd0, o_irq}, {31'd0, vecs[i].ei});
        end

        // Saturation: preload EVTCNT just below the top
        @(negedge clk);
        force dut.evtcnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.evtcnt_q;
        m_evt = 32'hFFFF_FFFE;
        repeat (3) tick(0, 0, 0, 0, 0, 1);
        tick(1, 3'd6, 0, 0, 0, 0);
        check("evtcnt saturate", o_rdata, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit        rd  = ($urandom_range(0, 1) == 1);
            bit [2:0]  rr  = 3'($urandom_range(0, 7));
            bit        wr  = ($urandom_range(0, 3) == 0);
            bit [2:0]  wi  = 3'($urandom_range(0, 7));
            bit [31:0] wd  = $urandom;
            bit        evt = ($urandom_range(0, 2) == 0);
            if (wi == 3'd3) wd = 32'($urandom_range(0, 6));
            tick(rd, rr, wr, wi, wd, evt);
            check($sformatf("rand%0d rdata", n), o_rdata, m_rdata);
            check($sformatf("rand%0d irq", n), {31'd0, o_irq}, {31'd0, m_exp & m_ctrl[2]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
